// File: rtl/sample_interp.sv
// Sample-rate interpolator: FIFO-fed linear ramp between consecutive
// input samples, stepped 2^S times per output period, feeding the DAC.
module sample_interp #(
  parameter int CLK_DIV      = 1000,
  parameter int INTERP_SHIFT = 3,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [15:0]        s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [15:0]        dac_sample,
  output logic               sample_tick,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int S     = INTERP_SHIFT;
  localparam int SUB   = CLK_DIV >> S;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = $clog2(CLK_DIV + 1);
  localparam int SW    = $clog2(SUB + 1);
  localparam int PW    = 18 + S;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB - 1);
  localparam logic [FIFO_AW:0] FULL  = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]      div_q;
  logic [SW-1:0]      sub_q;
  logic [S-1:0]       phase_q;
  logic signed [15:0] prev_q;
  logic signed [15:0] next_q;
  logic               primed_q;
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_q;
  logic [FIFO_AW-1:0] rd_q;
  logic [FIFO_AW:0]   level_q;
  logic [15:0]        dac_q;
  logic               und_q;

  logic tick;
  logic empty;
  logic push;
  logic pop;
  logic shift;
  logic miss;

  assign tick        = enable && (div_q == DIV_LAST);
  assign empty       = (level_q == '0);
  assign s_ready     = (level_q < FULL);
  assign push        = s_valid && s_ready;
  assign sample_tick = tick;
  assign underrun    = und_q;
  assign fifo_level  = level_q;
  assign dac_sample  = dac_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift   = 1'b0;
    miss    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = primed_q ? ST_RUN : ST_WAIT;
        ST_WAIT: begin
          if (tick && !empty) begin
            pop     = 1'b1;
            shift   = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            shift = 1'b1;
            pop   = !empty;
            miss  = empty;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Full-width product; the interpolated result is known to fit 16 bits
  logic signed [16:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sum;
  logic                 unused_hi;

  assign diff = {next_q[15], next_q} - {prev_q[15], prev_q};
  assign prod = diff * $signed({1'b0, phase_q});
  assign sum  = {{(PW-16){prev_q[15]}}, prev_q} + (prod >>> S);
  assign unused_hi = ^sum[PW-1:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      sub_q    <= '0;
      phase_q  <= '0;
      prev_q   <= '0;
      next_q   <= '0;
      primed_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      dac_q    <= '0;
      und_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      und_q   <= miss;
      if (!enable || tick) begin
        div_q   <= '0;
        sub_q   <= '0;
        phase_q <= '0;
      end else begin
        div_q <= div_q + DW'(1);
        if (sub_q == SUB_LAST) begin
          sub_q   <= '0;
          phase_q <= phase_q + S'(1);
        end else begin
          sub_q <= sub_q + SW'(1);
        end
      end
      if (shift) prev_q <= next_q;
      if (pop) begin
        next_q   <= mem[rd_q];
        rd_q     <= rd_q + FIFO_AW'(1);
        primed_q <= 1'b1;
      end
      if (push) wr_q <= wr_q + FIFO_AW'(1);
      if (push && !pop) level_q <= level_q + 1'b1;
      if (pop && !push) level_q <= level_q - 1'b1;
      if (enable) dac_q <= sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= s_data;
  end

endmodule

// File: tb/tb_sample_interp.sv
// Bench for sample_interp: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue model.
module tb_sample_interp;

  localparam int CD  = 16;
  localparam int S   = 2;
  localparam int SUB = CD >> S;
  localparam int DEP = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] dac_sample;
  logic        sample_tick;
  logic        underrun;
  logic [2:0]  fifo_level;

  sample_interp #(
    .CLK_DIV(CD),
    .INTERP_SHIFT(S),
    .FIFO_AW(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .dac_sample(dac_sample),
    .sample_tick(sample_tick),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycle position in the period, a queue for the FIFO,
  // and the pair of samples being ramped between.
  int          m_cnt;
  int          m_q[$];
  int          m_prev;
  int          m_next;
  bit          m_primed;
  logic [15:0] m_dac;
  bit          m_und;

  function automatic logic [15:0] interp(int p, int n, int ph);
    int d;
    d = (n - p) * ph;
    return 16'(p + (d >>> S));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int n0;
    bit tk;
    if (!rst_n) begin
      m_cnt = 0;
      m_q.delete();
      m_prev = 0;
      m_next = 0;
      m_primed = 0;
      m_dac = '0;
      m_und = 0;
    end else begin
      n0 = m_q.size();
      m_und = 0;
      if (enable) begin
        m_dac = interp(m_prev, m_next, m_cnt / SUB);
        tk = (m_cnt == CD - 1);
        if (tk) begin
          if (m_primed) begin
            m_prev = m_next;
            if (n0 > 0) m_next = m_q.pop_front();
            else m_und = 1;
          end else if (n0 > 0) begin
            m_prev = m_next;
            m_next = m_q.pop_front();
            m_primed = 1;
          end
        end
        m_cnt = tk ? 0 : m_cnt + 1;
      end else begin
        m_cnt = 0;
      end
      if (s_valid && n0 < DEP)
        m_q.push_back(int'($signed(s_data)));
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("dac", dac_sample, m_dac);
      check("tick", sample_tick, enable && m_cnt == CD - 1);
      check("underrun", underrun, m_und);
      check("level", fifo_level, m_q.size());
      check("s_ready", s_ready, m_q.size() < DEP);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 200);
    if (!sample_tick) check("tick_timeout", 0, 1);
  endtask

  logic [15:0] exp_b [4];
  int n;
  int cnt;

  initial begin
    exp_b = '{16'h7FFF, 16'h3FFF, 16'hFFFF, 16'hBFFF};
    rst_n = 1'b0;
    enable = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    #1;
    check("rst_dac", dac_sample, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 1);
    check("rst_tick", sample_tick, 0);
    check("rst_und", underrun, 0);
    cyc(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(2);

    // First sample ramps up from zero
    s_valid = 1'b1;
    s_data = 16'h1000;
    cyc(1);
    s_valid = 1'b0;
    enable = 1'b1;
    wait_tick(n);
    check("first_period", n, 16);
    check("wait_und", underrun, 0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k >= 2) check("ramp_a", dac_sample, 1024 * ((k - 2) / 4));
    end

    // Full-scale swing across the sign boundary
    @(posedge clk); #2;
    s_valid = 1'b1;
    s_data = 16'h7FFF;
    cyc(1);
    s_data = 16'h8000;
    cyc(1);
    s_valid = 1'b0;
    wait_tick(n);
    wait_tick(n);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k >= 2) check("ramp_b", dac_sample, exp_b[(k - 2) / 4]);
    end

    // Starved tick in RUN
    wait_tick(n);
    check("und_at_tick", underrun, 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) check("und_pulse", underrun, 1);
      if (k >= 2) check("und_flat", dac_sample, 16'h8000);
      if (k == 2) check("und_end", underrun, 0);
    end

    // Fill while disabled, then overflow attempt
    @(posedge clk); #2;
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      s_data = 16'(i * 256);
      @(negedge clk);
      check("fill_ready", s_ready, i <= 4);
      @(posedge clk); #2;
    end
    check("full_level", fifo_level, 4);
    enable = 1'b1;
    wait_tick(n);
    check("reenable_period", n, 16);
    check("tick_level", fifo_level, 4);
    @(negedge clk);
    check("pop_level", fifo_level, 3);
    check("pop_ready", s_ready, 1);
    @(negedge clk);
    check("refill_level", fifo_level, 4);

    // Drop enable mid-ramp: output frozen, period restarts
    @(posedge clk); #2;
    s_valid = 1'b0;
    cyc(4);
    enable = 1'b0;
    cyc(5);
    @(negedge clk);
    check("hold_dac", dac_sample, 16'hA040);
    check("hold_tick", sample_tick, 0);
    @(posedge clk); #2;
    enable = 1'b1;
    wait_tick(n);
    check("restart_period", n, 16);
    @(negedge clk);
    check("pre_rst_level", fifo_level, 3);

    // Asynchronous reset in the middle of RUN
    @(posedge clk); #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("mid_rst_dac", dac_sample, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_und", underrun, 0);
    cyc(2);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sample_tick) cnt++;
    end
    check("idle_ticks", cnt, 0);
    @(posedge clk); #2;
    enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (underrun) cnt++;
    end
    check("wait_no_und", cnt, 0);

    // Randomized traffic
    @(posedge clk); #2;
    for (int blk = 0; blk < 8; blk++) begin
      int pct;
      pct = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 7 : 30);
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 99) < 2) enable = ~enable;
        s_valid = ($urandom_range(0, 99) < pct);
        case ($urandom_range(0, 3))
          0: s_data = 16'h7FFF;
          1: s_data = 16'h8000;
          default: s_data = 16'($urandom);
        endcase
        cyc(1);
      end
    end
    s_valid = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_interp.md
SAMPLE_INTERP -- requirements
Module: sample_interp

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, meaning clk cycles per output sample period (48 MHz / 48 kHz).
REQ-002 SHALL have parameter INTERP_SHIFT (S), default 3, meaning log2 of interpolation sub-steps per sample period; CLK_DIV SHALL be a multiple of 2^S, and SUB = CLK_DIV >> S.
REQ-003 SHALL have parameter FIFO_AW, default 2, meaning log2 of FIFO depth (depth 4).
REQ-004 SHALL have port clk, input, 1 bit: single clock for the whole block.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: run the rate divider and the interpolator.
REQ-007 SHALL have port s_data, input, 16 bits: signed sample from the upstream source.
REQ-008 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-009 SHALL have port s_ready, output, 1 bit: FIFO can accept a sample.
REQ-010 SHALL have port dac_sample, output, 16 bits: signed interpolated sample, connected directly to sddac sig_in.
REQ-011 SHALL have port sample_tick, output, 1 bit: one-cycle pulse per sample period.
REQ-012 SHALL have port underrun, output, 1 bit: one-cycle pulse when a sample was due and the FIFO was empty.
REQ-013 SHALL have port fifo_level, output, FIFO_AW+1 bits: current FIFO occupancy.

Function
REQ-014 SHALL push a sample on a cycle with s_valid && s_ready; s_ready = (fifo_level < 2^FIFO_AW), a combinational function of registered level only.
REQ-015 SHALL accept pushes regardless of enable or state.
REQ-016 SHALL run the divider only while enable=1: div counts 0..CLK_DIV-1 and wraps; sample_tick is high on the cycle div==CLK_DIV-1.
REQ-017 SHALL run the phase counter (0..2^S-1) by incrementing it every SUB cycles and clearing it to 0 on sample_tick.
REQ-018 SHALL implement FSM IDLE: enable=0, div=0, phase=0, dac_sample holds its value; enable=1 moves to WAIT, or to RUN if a sample was previously popped.
REQ-019 SHALL implement FSM WAIT: ticks run, no underrun is reported, and a tick with the FIFO non-empty pops the sample (prev<=next, next<=head) and moves to RUN.
REQ-020 SHALL implement FSM RUN: on each tick, prev<=next, then next<=head with a pop if the FIFO is non-empty; otherwise next is unchanged and underrun pulses on the following cycle.
REQ-021 SHALL move from any state to IDLE on enable=0, clearing div and phase but retaining prev, next and FIFO contents.
REQ-022 SHALL change fifo_level by +1 on a push only, -1 on a pop only, and 0 on simultaneous push and pop; a pop of an empty FIFO SHALL never occur.
REQ-023 SHALL compute diff = next - prev as 17-bit signed and dac_sample = prev + ((diff * phase) >>> S) as an arithmetic floor shift, with the result fitting in 16 bits without saturation.
REQ-024 SHALL register dac_sample, so it follows prev/next/phase with 1 cycle latency.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: state IDLE, div 0, phase 0, prev 0, next 0, FIFO empty, fifo_level 0, s_ready 1, dac_sample 0, sample_tick 0, underrun 0.
REQ-026 SHALL discard FIFO contents on a reset mid-operation, and SHALL require a first sample to be popped before RUN is re-entered.

Verification (CLK_DIV=16, S=2, SUB=4)
REQ-027 SHALL cover: reset mid-RUN with fifo_level=3 -> same delta: dac_sample=0, fifo_level=0, s_ready=1; after release, no tick while enable=0.
REQ-028 SHALL cover: push 0x1000, enable=1 -> first tick pops 0x1000; over the next period dac_sample steps 0x0000, 0x0400, 0x0800, 0x0C00, 4 cycles each; no underrun while in WAIT.
REQ-029 SHALL cover: prev=0x7FFF, next=0x8000 -> dac_sample 0x7FFF, 0x3FFF, 0xFFFF, 0xBFFF, with no wrap glitch.
REQ-030 SHALL cover: RUN with the FIFO empty at a tick -> underrun high exactly 1 cycle; dac_sample flat at the last next value for the whole period.
REQ-031 SHALL cover: enable=0 and 5 consecutive valid pushes -> first 4 accepted, fifo_level=4, s_ready=0 on the 5th; at the next tick with enable=1 and s_valid held, the pop leaves fifo_level=3 and s_ready=1, and the following push restores it to 4.
REQ-032 SHALL cover: enable dropped mid-period -> div and phase return to 0, dac_sample held; re-enable restarts a full CLK_DIV period before the next tick.
